// File: rtl/register_file_pkg.sv
// Shared definitions for the register file and its read ports.
// Holds the default geometry, the hardwired-zero address and a helper
// that sizes array indices for a given depth.
package register_file_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_NUM_RD = 2;
  localparam int MAX_NUM_RD     = 4;

  // Address of the word that reads as zero when ZERO_REG is set
  localparam int ZERO_ADDR = 0;

  // Index width needed to address DEPTH words (at least one bit)
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port of the register file.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   readEn     read enable for this port
//   readAddr   read address for this port
//   words      current storage contents from the top level
//   wrAccept   the write port commits a word on this edge
//   writeAddr  address of that write
//   writeData  data of that write
//   readData   registered read data (holds when readEn is low)
//   readValid  high for the cycle after an accepted read
module read_port
  import register_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] readAddr,
  input  logic [WIDTH-1:0]  words [DEPTH],
  input  logic              wrAccept,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  writeData,
  output logic [WIDTH-1:0]  readData,
  output logic              readValid
);

  localparam int IDX_W = idxWidth(DEPTH);

  logic             inRange;
  logic             isZeroWord;
  logic             bypassHit;
  logic [IDX_W-1:0] readIdx;
  logic [WIDTH-1:0] nextData;

  // Select what this port will capture on the coming edge. A write that is
  // being committed on the same edge wins over the stored word; writes that
  // get dropped never raise wrAccept, so they can never be forwarded here.
  always_comb begin
    inRange    = 32'(readAddr) < DEPTH;
    isZeroWord = (ZERO_REG != 0) && (32'(readAddr) == ZERO_ADDR);
    bypassHit  = wrAccept && (writeAddr == readAddr);
    readIdx    = readAddr[IDX_W-1:0];
    nextData   = '0;
    if (bypassHit) begin
      nextData = writeData;
    end else if (inRange && !isZeroWord) begin
      nextData = words[readIdx];
    end
  end

  // Output register: data only moves on an accepted read, valid pulses once
  always_ff @(posedge clk) begin
    if (rst) begin
      readData  <= '0;
      readValid <= 1'b0;
    end else if (readEn) begin
      readData  <= nextData;
      readValid <= 1'b1;
    end else begin
      readValid <= 1'b0;
    end
  end

endmodule

// File: rtl/register_file.sv
// Multi-port register file for the CPU datapath: DEPTH words of WIDTH bits,
// one synchronous write port and NUM_RD registered, write-first read ports.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   regWrite   write enable
//   writeAddr  write address
//   writeData  write data
//   readEn     per-port read enables, bit i for port i
//   readAddr   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   readData   packed registered read data, port i at [i*WIDTH +: WIDTH]
//   readValid  per-port valid, high the cycle after an accepted read
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        writeAddr,
  input  logic [WIDTH-1:0]         writeData,
  input  logic [NUM_RD-1:0]        readEn,
  input  logic [NUM_RD*ADDR_W-1:0] readAddr,
  output logic [NUM_RD*WIDTH-1:0]  readData,
  output logic [NUM_RD-1:0]        readValid
);

  localparam int IDX_W = idxWidth(DEPTH);

  // Reject geometries the address bus cannot cover or unsupported port counts
  generate
    if ((2 ** ADDR_W) < DEPTH) begin : gBadAddrW
      $error("register_file: ADDR_W=%0d cannot address DEPTH=%0d", ADDR_W, DEPTH);
    end
    if ((NUM_RD < 1) || (NUM_RD > MAX_NUM_RD)) begin : gBadNumRd
      $error("register_file: NUM_RD=%0d outside 1..%0d", NUM_RD, MAX_NUM_RD);
    end
  endgenerate

  logic [WIDTH-1:0] words [DEPTH];
  logic             wrAccept;
  logic [IDX_W-1:0] writeIdx;

  // A write commits only outside reset, inside the array and, when the zero
  // word is hardwired, never to word 0. The same flag drives read bypass.
  always_comb begin
    wrAccept = regWrite && !rst && (32'(writeAddr) < DEPTH) &&
               !((ZERO_REG != 0) && (32'(writeAddr) == ZERO_ADDR));
    writeIdx = writeAddr[IDX_W-1:0];
  end

  // Storage: reset clears every word, otherwise commit the accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        words[i] <= '0;
      end
    end else if (wrAccept) begin
      words[writeIdx] <= writeData;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : gReadPort
      read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
      ) uReadPort (
        .clk      (clk),
        .rst      (rst),
        .readEn   (readEn[p]),
        .readAddr (readAddr[p*ADDR_W +: ADDR_W]),
        .words    (words),
        .wrAccept (wrAccept),
        .writeAddr(writeAddr),
        .writeData(writeData),
        .readData (readData[p*WIDTH +: WIDTH]),
        .readValid(readValid[p])
      );
    end
  endgenerate

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file. A default instance (32 words,
// zero register enabled) and a 16-word instance share the same stimulus.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [1:0]  readEn;
  logic [9:0]  readAddr;
  logic [63:0] readData;
  logic [1:0]  readValid;
  logic [63:0] smallData;
  logic [1:0]  smallValid;

  int testCount;
  int failCount;

  register_file #(
    .WIDTH(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .writeAddr(writeAddr),
    .writeData(writeData), .readEn(readEn), .readAddr(readAddr),
    .readData(readData), .readValid(readValid)
  );

  register_file #(
    .WIDTH(32), .DEPTH(16), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) dutSmall (
    .clk(clk), .rst(rst), .regWrite(regWrite), .writeAddr(writeAddr),
    .writeData(writeData), .readEn(readEn), .readAddr(readAddr),
    .readData(smallData), .readValid(smallValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set every input for the next edge; port 1 address, port 0 address
  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [1:0] re,
                               input logic [4:0] ra1, input logic [4:0] ra0);
    rst       = r;
    regWrite  = we;
    writeAddr = wa;
    writeData = wd;
    readEn    = re;
    readAddr  = {ra1, ra0};
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5);
    tick();
    testCount++;
    if (readValid !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL reset_valid: got %b expected %b", readValid, 2'b00);
    end
    testCount++;
    if (readData !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL reset_data: got %h expected %h", readData, 64'h0);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5);
    tick();
    testCount++;
    if (readData !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL post_reset_read_data: got %h expected %h", readData, 64'h0);
    end
    testCount++;
    if (readValid !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL post_reset_read_valid: got %b expected %b", readValid, 2'b11);
    end
  endtask

  task automatic test_write_read();
    applyStimulus(0, 1, 5'd7, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0);
    tick();
    testCount++;
    if (readValid !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL write_no_read_valid: got %b expected %b", readValid, 2'b00);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd7);
    tick();
    testCount++;
    if (readData[31:0] !== 32'hDEADBEEF) begin
      failCount++;
      $display("[TB] FAIL read_after_write: got %h expected %h", readData[31:0], 32'hDEADBEEF);
    end
    testCount++;
    if (readData[63:32] !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL idle_port1_hold: got %h expected %h", readData[63:32], 32'h0);
    end
    testCount++;
    if (readValid !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL read_after_write_valid: got %b expected %b", readValid, 2'b01);
    end
  endtask

  task automatic test_bypass();
    applyStimulus(0, 1, 5'd3, 32'h12345678, 2'b10, 5'd3, 5'd7);
    tick();
    testCount++;
    if (readData[63:32] !== 32'h12345678) begin
      failCount++;
      $display("[TB] FAIL bypass_port1: got %h expected %h", readData[63:32], 32'h12345678);
    end
    testCount++;
    if (readData[31:0] !== 32'hDEADBEEF) begin
      failCount++;
      $display("[TB] FAIL bypass_port0_hold: got %h expected %h", readData[31:0], 32'hDEADBEEF);
    end
    testCount++;
    if (readValid !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL bypass_valid: got %b expected %b", readValid, 2'b10);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd3);
    tick();
    testCount++;
    if (readData !== {32'h12345678, 32'h12345678}) begin
      failCount++;
      $display("[TB] FAIL same_addr_both_ports: got %h expected %h", readData,
               {32'h12345678, 32'h12345678});
    end
  endtask

  task automatic test_zero_reg();
    applyStimulus(0, 1, 5'd0, 32'hFFFFFFFF, 2'b01, 5'd0, 5'd0);
    tick();
    testCount++;
    if (readData[31:0] !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL zero_reg_bypass: got %h expected %h", readData[31:0], 32'h0);
    end
    testCount++;
    if (readValid !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL zero_reg_bypass_valid: got %b expected %b", readValid, 2'b01);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0);
    tick();
    testCount++;
    if (readData !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL zero_reg_read: got %h expected %h", readData, 64'h0);
    end
  endtask

  task automatic test_hold();
    applyStimulus(0, 1, 5'd12, 32'hA5A5A5A5, 2'b00, 5'd0, 5'd0);
    tick();
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd12);
    tick();
    testCount++;
    if (readData[31:0] !== 32'hA5A5A5A5) begin
      failCount++;
      $display("[TB] FAIL hold_setup_read: got %h expected %h", readData[31:0], 32'hA5A5A5A5);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd7);
    tick();
    tick();
    testCount++;
    if (readData[31:0] !== 32'hA5A5A5A5) begin
      failCount++;
      $display("[TB] FAIL hold_data: got %h expected %h", readData[31:0], 32'hA5A5A5A5);
    end
    testCount++;
    if (readValid !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL hold_valid: got %b expected %b", readValid, 2'b00);
    end
  endtask

  task automatic test_reset_write();
    applyStimulus(1, 1, 5'd9, 32'h55, 2'b11, 5'd9, 5'd9);
    tick();
    testCount++;
    if (readValid !== 2'b00) begin
      failCount++;
      $display("[TB] FAIL reset_cycle_read_discarded: got %b expected %b", readValid, 2'b00);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd7, 5'd9);
    tick();
    testCount++;
    if (readData !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL reset_blocks_write: got %h expected %h", readData, 64'h0);
    end
    testCount++;
    if (readValid !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL reset_blocks_write_valid: got %b expected %b", readValid, 2'b11);
    end
  endtask

  task automatic test_out_of_range();
    applyStimulus(0, 1, 5'd20, 32'h99, 2'b01, 5'd0, 5'd20);
    tick();
    testCount++;
    if (smallData[31:0] !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL oor_no_bypass: got %h expected %h", smallData[31:0], 32'h0);
    end
    testCount++;
    if (smallValid !== 2'b01) begin
      failCount++;
      $display("[TB] FAIL oor_bypass_valid: got %b expected %b", smallValid, 2'b01);
    end
    testCount++;
    if (readData[31:0] !== 32'h99) begin
      failCount++;
      $display("[TB] FAIL in_range_bypass_addr20: got %h expected %h", readData[31:0], 32'h99);
    end
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd20);
    tick();
    testCount++;
    if (smallData !== 64'h0) begin
      failCount++;
      $display("[TB] FAIL oor_read_and_alias: got %h expected %h", smallData, 64'h0);
    end
    testCount++;
    if (smallValid !== 2'b11) begin
      failCount++;
      $display("[TB] FAIL oor_read_valid: got %b expected %b", smallValid, 2'b11);
    end
    applyStimulus(0, 1, 5'd15, 32'hCAFE, 2'b00, 5'd0, 5'd0);
    tick();
    applyStimulus(0, 0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd15);
    tick();
    testCount++;
    if (smallData[31:0] !== 32'hCAFE) begin
      failCount++;
      $display("[TB] FAIL top_word_small: got %h expected %h", smallData[31:0], 32'hCAFE);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    applyStimulus(1, 0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hold();
    test_reset_write();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
